// File: rtl/relu_maxpool_writer.sv
// ReLU + 2x2 stride-2 max pooling over a raster FP16 pixel stream, writing pooled results to an output BRAM.
// Optional build macro RELU_MAXPOOL_SIGNED_EN: bypass ReLU and pool raw values with a sign-magnitude compare.
module relu_maxpool_writer #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [15:0]       in_pixel,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [15:0]       bram_wdata,
    output logic              busy,
    output logic              frame_done
);

    localparam int HALF_W = IMG_W / 2;
    localparam int COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LB_W   = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] pointer;
    logic [15:0]       pair;
    logic [15:0]       linebuf [HALF_W];

    logic [15:0]       act;
    logic [15:0]       hmax;
    logic [15:0]       result;
    logic [LB_W-1:0]   lb_idx;
    logic              col_last;
    logic              row_last;
    logic              accept;

    // Ordering key: an unsigned compare of keys gives the pooling order.
    // Signed build maps negatives below positives, smaller magnitude higher, -0 just under +0.
    function automatic logic [15:0] rank_key(input logic [15:0] v);
`ifdef RELU_MAXPOOL_SIGNED_EN
        return v[15] ? {1'b0, ~v[14:0]} : {1'b1, v[14:0]};
`else
        return v;
`endif
    endfunction

    // Ties keep the earlier operand a.
    function automatic logic [15:0] pick_max(input logic [15:0] a, input logic [15:0] b);
        return (rank_key(b) > rank_key(a)) ? b : a;
    endfunction

    always_comb begin
`ifdef RELU_MAXPOOL_SIGNED_EN
        act = in_pixel;
`else
        act = in_pixel[15] ? 16'h0000 : in_pixel;
`endif
        lb_idx   = LB_W'(col >> 1);
        hmax     = pick_max(pair, act);
        result   = pick_max(linebuf[lb_idx], hmax);
        col_last = (col == COL_W'(IMG_W - 1));
        row_last = (row == ROW_W'(IMG_H - 1));
        accept   = (state == RUN) && in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            pointer    <= '0;
            pair       <= '0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            bram_we    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        pointer <= base_addr;
                        col     <= '0;
                        row     <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (!col[0]) begin
                            pair <= act;
                        end else if (row[0]) begin
                            // Fourth pixel of a window: emit the pooled value next cycle.
                            bram_we    <= 1'b1;
                            bram_wdata <= result;
                            bram_addr  <= pointer;
                            pointer    <= pointer + ADDR_W'(1);
                        end
                        if (col_last) begin
                            col <= '0;
                            if (row_last) begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                            end else begin
                                row <= row + ROW_W'(1);
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Horizontal maxima of even rows, consumed by the odd row below.
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0]) begin
            linebuf[lb_idx] <= hmax;
        end
    end

endmodule
